gpio_ctrl: RTL

//  Parametrised memory-mapped GPIO controller on the SoC data bus; word-addressed, 8 registers.

---
 rtl/gpio_pkg.sv | 21 ++
 rtl/gpio_sync.sv | 36 +++
 rtl/gpio_ctrl.sv | 115 +++++++++++
 3 files changed

// File: rtl/gpio_pkg.sv
// Register map and shared helpers for the memory-mapped GPIO controller.
package gpio_pkg;

  localparam int unsigned GPIO_AW = 3;

  localparam logic [GPIO_AW-1:0] GPIO_DIN  = 3'd0;
  localparam logic [GPIO_AW-1:0] GPIO_STAT = 3'd1;
  localparam logic [GPIO_AW-1:0] GPIO_DOUT = 3'd2;
  localparam logic [GPIO_AW-1:0] GPIO_DIR  = 3'd3;
  localparam logic [GPIO_AW-1:0] GPIO_IEN  = 3'd4;
  localparam logic [GPIO_AW-1:0] GPIO_EDGE = 3'd5;
  localparam logic [GPIO_AW-1:0] GPIO_DSET = 3'd6;
  localparam logic [GPIO_AW-1:0] GPIO_DCLR = 3'd7;

  // True when the bus is writing the register at reg_a this cycle.
  function automatic logic is_write(input logic we, input logic [GPIO_AW-1:0] a,
                                    input logic [GPIO_AW-1:0] reg_a);
    return we && (a == reg_a);
  endfunction

endpackage

// File: rtl/gpio_sync.sv
// Multi-stage input synchroniser for asynchronous pad inputs, with synchronous clear.
module gpio_sync #(
  parameter int unsigned W      = 32,
  parameter int unsigned STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] sync_q [STAGES];
  logic [W-1:0] sync_d [STAGES];

  always_comb begin
    sync_d[0] = d;
    for (int unsigned i = 1; i < STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/gpio_ctrl.sv
// Memory-mapped GPIO controller: register file, synchronised inputs,
// per-bit edge detection with sticky W1C status and a level interrupt.
module gpio_ctrl
  import gpio_pkg::*;
#(
  parameter int unsigned   W           = 32,
  parameter int unsigned   SYNC_STAGES = 2,
  parameter logic [W-1:0]  RST_DOUT    = '0,
  parameter logic [W-1:0]  RST_DIR     = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [GPIO_AW-1:0] a,
  input  logic               we,
  input  logic [W-1:0]       wd,
  output logic [W-1:0]       rd,
  input  logic [W-1:0]       gpio_i,
  output logic [W-1:0]       gpio_o,
  output logic [W-1:0]       gpio_oe,
  output logic               irq
);

  logic [W-1:0] din;
  logic [W-1:0] dout_q, dout_d;
  logic [W-1:0] dir_q,  dir_d;
  logic [W-1:0] ien_q,  ien_d;
  logic [W-1:0] edge_q, edge_d;
  logic [W-1:0] stat_q, stat_d;
  logic [W-1:0] prev_q, prev_d;
  logic         irq_q,  irq_d;

  logic [W-1:0] rise;
  logic [W-1:0] fall;
  logic [W-1:0] ev;
  logic [W-1:0] stat_clr;

  gpio_sync #(
    .W      (W),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (gpio_i),
    .q     (din)
  );

  // Edge events are gated by IEN at detection time, so masked edges are lost.
  always_comb begin
    rise     = din & ~prev_q;
    fall     = ~din & prev_q;
    ev       = ien_q & ((edge_q & rise) | (~edge_q & fall));
    stat_clr = is_write(we, a, GPIO_STAT) ? wd : '0;
  end

  always_comb begin
    dout_d = dout_q;
    dir_d  = dir_q;
    ien_d  = ien_q;
    edge_d = edge_q;
    prev_d = din;
    // Set wins over a simultaneous W1C on the same bit.
    stat_d = (stat_q & ~stat_clr) | ev;
    irq_d  = |stat_d;
    if (we) begin
      case (a)
        GPIO_DOUT: dout_d = wd;
        GPIO_DIR:  dir_d  = wd;
        GPIO_IEN:  ien_d  = wd;
        GPIO_EDGE: edge_d = wd;
        GPIO_DSET: dout_d = dout_q | wd;
        GPIO_DCLR: dout_d = dout_q & ~wd;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout_q <= RST_DOUT;
      dir_q  <= RST_DIR;
      ien_q  <= '0;
      edge_q <= '0;
      stat_q <= '0;
      prev_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      dout_q <= dout_d;
      dir_q  <= dir_d;
      ien_q  <= ien_d;
      edge_q <= edge_d;
      stat_q <= stat_d;
      prev_q <= prev_d;
      irq_q  <= irq_d;
    end
  end

  // Single-cycle read path; write-only set/clear aliases read as zero.
  always_comb begin
    rd = '0;
    case (a)
      GPIO_DIN:  rd = din;
      GPIO_STAT: rd = stat_q;
      GPIO_DOUT: rd = dout_q;
      GPIO_DIR:  rd = dir_q;
      GPIO_IEN:  rd = ien_q;
      GPIO_EDGE: rd = edge_q;
      default:   rd = '0;
    endcase
  end

  assign gpio_o  = dout_q;
  assign gpio_oe = dir_q;
  assign irq     = irq_q;

endmodule
